// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin request arbiter with registered output stage and ID-routed responses
module memory_bus_arbiter #(
   parameter int N_MASTERS       = 4,
   parameter int MASTER_ID_WIDTH = 8,
   parameter int ADDRESS_WIDTH   = 32,
   parameter int DATA_WIDTH      = 16,
   localparam int IDX_W          = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_MASTERS*MASTER_ID_WIDTH-1:0] up_msID,
   input  logic [N_MASTERS*ADDRESS_WIDTH-1:0]   up_msAddress,
   input  logic [N_MASTERS*DATA_WIDTH-1:0]      up_msData,
   input  logic [N_MASTERS-1:0]                 up_msWrite,
   input  logic [N_MASTERS-1:0]                 up_msValid,
   output logic [N_MASTERS-1:0]                 up_msTaken,
   output logic [N_MASTERS*MASTER_ID_WIDTH-1:0] up_smID,
   output logic [N_MASTERS*DATA_WIDTH-1:0]      up_smData,
   output logic [N_MASTERS-1:0]                 up_smValid,
   input  logic [N_MASTERS-1:0]                 up_smTaken,
   output logic [MASTER_ID_WIDTH-1:0]           dn_msID,
   output logic [ADDRESS_WIDTH-1:0]             dn_msAddress,
   output logic [DATA_WIDTH-1:0]                dn_msData,
   output logic                                 dn_msWrite,
   output logic                                 dn_msValid,
   input  logic                                 dn_msTaken,
   input  logic [MASTER_ID_WIDTH-1:0]           dn_smID,
   input  logic [DATA_WIDTH-1:0]                dn_smData,
   input  logic                                 dn_smValid,
   output logic                                 dn_smTaken,
   output logic                                 bad_id
);
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] winner;
   logic             found;
   logic             can_load;
   logic             grant;
   logic [IDX_W-1:0] sel;
   logic             routable;

   // rotating priority search starting just after the previous winner
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         if (!found && up_msValid[(int'(last_grant) + k) % N_MASTERS]) begin
            found  = 1'b1;
            winner = IDX_W'((int'(last_grant) + k) % N_MASTERS);
         end
      end
   end

   assign can_load   = !dn_msValid || dn_msTaken;
   assign grant      = can_load && found && !rst;
   assign up_msTaken = grant ? (N_MASTERS'(1) << winner) : '0;

   // output register: load the winner, drain on downstream accept, discard on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         dn_msValid   <= 1'b0;
         dn_msID      <= '0;
         dn_msAddress <= '0;
         dn_msData    <= '0;
         dn_msWrite   <= 1'b0;
         last_grant   <= IDX_W'(N_MASTERS - 1);
      end else if (grant) begin
         dn_msValid   <= 1'b1;
         dn_msID      <= up_msID[int'(winner)*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
         dn_msAddress <= up_msAddress[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         dn_msData    <= up_msData[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
         dn_msWrite   <= up_msWrite[winner];
         last_grant   <= winner;
      end else if (dn_msTaken) begin
         dn_msValid   <= 1'b0;
      end
   end

   assign sel        = dn_smID[IDX_W-1:0];
   assign routable   = int'(sel) < N_MASTERS;
   assign up_smID    = {N_MASTERS{dn_smID}};
   assign up_smData  = {N_MASTERS{dn_smData}};
   assign up_smValid = (routable && dn_smValid) ? (N_MASTERS'(1) << sel) : '0;
   assign dn_smTaken = routable ? up_smTaken[sel] : 1'b1;

   // sticky record of dropped responses whose ID names no master
   always_ff @(posedge clk) begin
      if (rst) bad_id <= 1'b0;
      else if (dn_smValid && !routable) bad_id <= 1'b1;
   end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed checks of arbitration, backpressure, response routing and reset
module tb_memory_bus_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0]  up_msID;
   logic [127:0] up_msAddress;
   logic [63:0]  up_msData;
   logic [3:0]   up_msWrite, up_msValid, up_msTaken;
   logic [31:0]  up_smID;
   logic [63:0]  up_smData;
   logic [3:0]   up_smValid, up_smTaken;
   logic [7:0]   dn_msID;
   logic [31:0]  dn_msAddress;
   logic [15:0]  dn_msData;
   logic         dn_msWrite, dn_msValid, dn_msTaken;
   logic [7:0]   dn_smID;
   logic [15:0]  dn_smData;
   logic         dn_smValid, dn_smTaken, bad_id;

   logic [2:0]   t_msTaken, t_smValid;
   logic [23:0]  t_smID;
   logic [47:0]  t_smData;
   logic [7:0]   t_msID;
   logic [31:0]  t_msAddress;
   logic [15:0]  t_msData;
   logic         t_msWrite, t_msValid;
   logic [7:0]   t_dn_smID;
   logic         t_dn_smValid, t_smTaken, t_bad_id;

   memory_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .up_msID(up_msID), .up_msAddress(up_msAddress), .up_msData(up_msData),
      .up_msWrite(up_msWrite), .up_msValid(up_msValid), .up_msTaken(up_msTaken),
      .up_smID(up_smID), .up_smData(up_smData), .up_smValid(up_smValid), .up_smTaken(up_smTaken),
      .dn_msID(dn_msID), .dn_msAddress(dn_msAddress), .dn_msData(dn_msData),
      .dn_msWrite(dn_msWrite), .dn_msValid(dn_msValid), .dn_msTaken(dn_msTaken),
      .dn_smID(dn_smID), .dn_smData(dn_smData), .dn_smValid(dn_smValid), .dn_smTaken(dn_smTaken),
      .bad_id(bad_id)
   );

   memory_bus_arbiter #(.N_MASTERS(3)) dut3 (
      .clk(clk), .rst(rst),
      .up_msID(24'h0), .up_msAddress(96'h0), .up_msData(48'h0),
      .up_msWrite(3'b000), .up_msValid(3'b000), .up_msTaken(t_msTaken),
      .up_smID(t_smID), .up_smData(t_smData), .up_smValid(t_smValid), .up_smTaken(3'b000),
      .dn_msID(t_msID), .dn_msAddress(t_msAddress), .dn_msData(t_msData),
      .dn_msWrite(t_msWrite), .dn_msValid(t_msValid), .dn_msTaken(1'b1),
      .dn_smID(t_dn_smID), .dn_smData(16'h1234), .dn_smValid(t_dn_smValid), .dn_smTaken(t_smTaken),
      .bad_id(t_bad_id)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic load_all();
      for (int k = 0; k < 4; k++) begin
         up_msID[k*8 +: 8]        = 8'h20 | 8'(k);
         up_msAddress[k*32 +: 32] = 32'h1000 + 32'(k);
         up_msData[k*16 +: 16]    = 16'hA000 + 16'(k);
         up_msWrite[k]            = k[0];
      end
   endtask

   initial begin
      up_msID = '0; up_msAddress = '0; up_msData = '0; up_msWrite = '0; up_msValid = '0;
      up_smTaken = '0; dn_msTaken = 1'b0; dn_smID = '0; dn_smData = '0; dn_smValid = 1'b0;
      t_dn_smID = '0; t_dn_smValid = 1'b0;
      rst = 1'b1;
      step(); step();
      #1;
      chk("reset dn_msValid", dn_msValid, 0);
      chk("reset dn_msAddress", dn_msAddress, 0);
      chk("reset up_msTaken", up_msTaken, 0);
      chk("reset bad_id", bad_id, 0);

      // single master 2 write
      step();
      rst = 1'b0;
      up_msID[16 +: 8] = 8'h02; up_msAddress[64 +: 32] = 32'h100; up_msData[32 +: 16] = 16'hBEEF;
      up_msWrite = 4'b0100; up_msValid = 4'b0100; dn_msTaken = 1'b1;
      #1 chk("single taken", up_msTaken, 4'b0100);
      step();
      up_msValid = 4'b0000;
      #1;
      chk("single valid", dn_msValid, 1);
      chk("single addr", dn_msAddress, 32'h100);
      chk("single data", dn_msData, 16'hBEEF);
      chk("single write", dn_msWrite, 1);
      chk("single id", dn_msID, 8'h02);
      chk("single no regrant", up_msTaken, 0);
      step();
      #1 chk("single drained", dn_msValid, 0);

      // round robin from fresh reset: 0,1,2,3,0,1
      rst = 1'b1;
      step();
      rst = 1'b0;
      load_all();
      up_msValid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr grant", up_msTaken, 4'b0001 << (i % 4));
         if (i > 0) begin
            chk("rr out valid", dn_msValid, 1);
            chk("rr out id", dn_msID, 8'h20 | 8'((i - 1) % 4));
         end
         step();
      end
      #1;
      chk("rr last id", dn_msID, 8'h21);
      chk("rr last write", dn_msWrite, 1);

      // backpressure with masters 1 and 3 requesting
      up_msValid = 4'b1010;
      dn_msTaken = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp no taken", up_msTaken, 0);
         chk("bp addr stable", dn_msAddress, 32'h1001);
         chk("bp valid held", dn_msValid, 1);
         step();
      end
      dn_msTaken = 1'b1;
      #1 chk("bp release grant 3", up_msTaken, 4'b1000);
      step();
      up_msValid = 4'b0010;
      #1;
      chk("bp out id 3", dn_msID, 8'h23);
      chk("bp next grant 1", up_msTaken, 4'b0010);
      step();
      up_msValid = 4'b0000;
      #1 chk("bp out id 1", dn_msID, 8'h21);
      step();
      #1 chk("bp idle drain", dn_msValid, 0);

      // response routing on 4-master instance
      dn_smID = 8'h13; dn_smData = 16'h5A5A; dn_smValid = 1'b1; up_smTaken = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("rsp valid sel3", up_smValid, 4'b1000);
         chk("rsp not taken", dn_smTaken, 0);
         step();
      end
      up_smTaken = 4'b0111;
      #1 chk("rsp others ignored", dn_smTaken, 0);
      chk("rsp data bcast", up_smData, {4{16'h5A5A}});
      chk("rsp id bcast", up_smID, {4{8'h13}});
      step();
      up_smTaken = 4'b1000;
      #1 chk("rsp taken sel3", dn_smTaken, 1);
      step();
      dn_smID = 8'h40; up_smTaken = 4'b0001;
      #1;
      chk("rsp valid sel0", up_smValid, 4'b0001);
      chk("rsp taken sel0", dn_smTaken, 1);
      step();
      dn_smValid = 1'b0;
      #1;
      chk("rsp idle", up_smValid, 0);
      chk("rsp bad_id clear", bad_id, 0);

      // unroutable ID on 3-master instance
      t_dn_smID = 8'h05; t_dn_smValid = 1'b1;
      #1 chk("n3 route sel1", t_smValid, 3'b010);
      step();
      #1 chk("n3 no bad yet", t_bad_id, 0);
      t_dn_smID = 8'h07;
      #1;
      chk("n3 drop taken", t_smTaken, 1);
      chk("n3 drop no valid", t_smValid, 0);
      step();
      t_dn_smValid = 1'b0;
      #1 chk("n3 bad set", t_bad_id, 1);
      step(); step();
      #1 chk("n3 bad sticky", t_bad_id, 1);

      // reset mid-transfer
      dn_msTaken = 1'b0;
      up_msValid = 4'b0100;
      #1 chk("mid grant 2", up_msTaken, 4'b0100);
      step();
      up_msValid = 4'b0000;
      #1 chk("mid pending", dn_msValid, 1);
      step();
      rst = 1'b1;
      up_msValid = 4'b1001;
      #1 chk("mid rst no taken", up_msTaken, 0);
      step();
      rst = 1'b0;
      #1;
      chk("mid discarded", dn_msValid, 0);
      chk("mid bad cleared", t_bad_id, 0);
      chk("mid master0 first", up_msTaken, 4'b0001);
      step();
      up_msValid = 4'b0000;
      #1 chk("mid out id 0", dn_msID, 8'h20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares one MemoryBus slave port (RAM or scene memory) between N_MASTERS ray-tracing masters.
- Request (ms) channel: round-robin arbitration into a registered output stage, so full throughput is one transfer per cycle.
- Response (sm) channel: each response is routed back to its master by decoding smID.
- Sits between the ray units and the memory controller. Upstream it exposes N Slave-side ports; downstream it exposes one Master-side port.

Parameters:
- N_MASTERS, 4, number of upstream masters (2..16).
- MASTER_ID_WIDTH, 8, ID width. Must be ≥ IDX_W.
- ADDRESS_WIDTH, 32, address width.
- DATA_WIDTH, 16, data width.
- IDX_W (derived), max(1, clog2(N_MASTERS)), master index width.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- up_msID  in  N*MASTER_ID_WIDTH  per-master request ID. Slice i belongs to master i.
- up_msAddress  in  N*ADDRESS_WIDTH  per-master address.
- up_msData  in  N*DATA_WIDTH  per-master write data.
- up_msWrite  in  N  per-master write flag.
- up_msValid  in  N  per-master request valid.
- up_msTaken  out  N  per-master request accepted.
- up_smID  out  N*MASTER_ID_WIDTH  response ID, broadcast to all masters.
- up_smData  out  N*DATA_WIDTH  response data, broadcast to all masters.
- up_smValid  out  N  per-master response valid. At most one bit is high.
- up_smTaken  in  N  per-master response accepted.
- dn_msID, dn_msAddress, dn_msData, dn_msWrite, dn_msValid  out  per bus widths  downstream request.
- dn_msTaken  in  1  downstream request accepted.
- dn_smID, dn_smData, dn_smValid  in  per bus widths  downstream response.
- dn_smTaken  out  1  downstream response accepted.
- bad_id  out  1  sticky flag: a response with an unroutable ID was dropped.

Behaviour:
- Handshake rule: a transfer occurs on a cycle where Valid && Taken are both high. A producer holds Valid and its payload stable until the transfer.
- Reset values:
  - dn_msValid=0, all dn_ms payload=0.
  - up_msTaken=0.
  - bad_id=0.
  - last_grant=N_MASTERS-1, so master 0 has first priority.
- Request stage is a single output register (out_valid drives dn_msValid).
  - can_load = !out_valid || dn_msTaken.
  - If can_load and any up_msValid is set:
    - Winner = first requesting index searching last_grant+1, last_grant+2, … modulo N_MASTERS.
    - up_msTaken[winner]=1 combinationally in that cycle.
    - The winner's payload is registered into the dn_ms signals next edge, with out_valid=1.
    - last_grant is set to winner.
  - If can_load and no requester: out_valid is cleared next edge when dn_msTaken was high. last_grant is unchanged.
  - If !can_load: up_msTaken=0 for all masters; the output register holds.
- Latency and throughput:
  - 1 cycle from acceptance to dn_msValid.
  - Back-to-back: while dn_msTaken stays high, one request per cycle is forwarded.
  - Masters that requested continuously are granted in strict rotation.
- msID passes through unmodified. System rule: master k uses IDs whose low IDX_W bits equal k.
- Response path is combinational, with no storage.
  - sel = dn_smID[IDX_W-1:0].
  - If sel < N_MASTERS: up_smValid[sel] = dn_smValid and dn_smTaken = up_smTaken[sel].
  - up_smID and up_smData are dn_smID and dn_smData replicated to every slice.
  - If sel ≥ N_MASTERS (N not a power of 2): the response is dropped. dn_smTaken=1, no up_smValid is asserted, and bad_id is set on the cycle dn_smValid is high. bad_id clears only on rst.
- Request and response paths are independent. A simultaneous grant and response in the same cycle is legal.
- Reset mid-operation:
  - A pending dn_ms request is discarded (dn_msValid=0 next cycle).
  - up_msTaken stays low during rst.
  - Masters must re-present their requests.
- No combinational path from dn_msTaken to dn_msValid. dn_msTaken does feed up_msTaken combinationally.

Test Plan:
- Single master: after reset, master 2 issues write addr 0x100 data 0xBEEF id 0x02 with dn_msTaken=1 → up_msTaken[2] high in cycle 0. Next cycle dn_msValid=1, dn_msAddress=0x100, dn_msData=0xBEEF, dn_msWrite=1, dn_msID=0x02.
- Round-robin fairness: all 4 masters hold valid, dn_msTaken=1 → grant order 0,1,2,3,0,1…, one grant per cycle, no bubbles.
- Backpressure: dn_msTaken=0 for 5 cycles while masters 1 and 3 request → no up_msTaken; dn_ms payload stable. When taken rises, the next grant goes to the index after the held winner.
- Response routing: dn_smID=0x13 (sel=3), dn_smValid=1, up_smTaken[3]=0 for 2 cycles then 1 → only up_smValid[3] is high. dn_smTaken mirrors up_smTaken[3]; up_smData equals dn_smData.
- Unroutable ID with N_MASTERS=3: dn_smID=0x07 (sel=3), dn_smValid=1 → dn_smTaken=1, all up_smValid=0, bad_id=1 and stays set until rst.
- Reset mid-transfer: assert rst while dn_msValid=1 and dn_msTaken=0 → next cycle dn_msValid=0 and bad_id=0. After rst, master 0 wins first.
